// File: rtl/alu_pkg.sv
// Shared constants for the 64-bit ALU: operand width and opcode encodings.
package alu_pkg;

    localparam int WIDTH = 64;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

endpackage

// File: rtl/division_block.sv
// Combinational unsigned divider; a zero divisor yields an all-ones quotient
// and returns the dividend as the remainder.
module division_block
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH:0]   remainder
);

    always_comb begin
        quotient  = '1;
        remainder = {1'b0, a};
        if (b != '0) begin
            quotient  = a / b;
            remainder = {1'b0, a % b};
        end
    end

endmodule

// File: rtl/alu_64.sv
// Single-cycle registered ALU: every op loads out at the edge its inputs are
// sampled; the remainder register only moves on DIV.
module alu_64
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH:0]   division_remainder
);

    logic [WIDTH-1:0] quotient;
    logic [WIDTH:0]   remainder;

    division_block #(.WIDTH(WIDTH)) u_division_block (
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out                <= '0;
            division_remainder <= '0;
        end else begin
            case (op)
                OP_ADD: out <= a + b;
                OP_SUB: out <= a - b;
                OP_MUL: out <= a * b;
                OP_DIV: begin
                    out                <= quotient;
                    division_remainder <= remainder;
                end
                OP_AND: out <= a & b;
                OP_OR:  out <= a | b;
                OP_XOR: out <= a ^ b;
                OP_NOT: out <= ~a;
                OP_SHL: out <= {a[WIDTH-2:0], 1'b0};
                OP_SHR: out <= {1'b0, a[WIDTH-1:1]};
                // Unassigned opcodes leave both result registers untouched.
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// Directed and randomized checks of alu_64 against an arithmetic reference model.
module tb_alu_64;
    import alu_pkg::*;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [WIDTH-1:0] out;
    logic [WIDTH:0]   division_remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] m_out;
    logic [WIDTH:0]   m_rem;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_64 dut (
        .clk                (clk),
        .reset              (reset),
        .a                  (a),
        .b                  (b),
        .op                 (op),
        .out                (out),
        .division_remainder (division_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results from plain wide arithmetic on the operand values.
    task automatic model_apply(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] w;
        logic [127:0] two64;
        two64 = 128'd1 << 64;
        case (o)
            4'd0: begin w = (128'(x) + 128'(y)) % two64; m_out = w[63:0]; end
            4'd1: begin w = (two64 + 128'(x) - 128'(y)) % two64; m_out = w[63:0]; end
            4'd2: begin w = (128'(x) * 128'(y)) % two64; m_out = w[63:0]; end
            4'd3: begin
                if (y == 64'd0) begin
                    m_out = ONES;
                    m_rem = {1'b0, x};
                end else begin
                    m_out = x / y;
                    m_rem = {1'b0, x % y};
                end
            end
            4'd4: m_out = x & y;
            4'd5: m_out = x | y;
            4'd6: m_out = x ^ y;
            4'd7: m_out = ~x;
            4'd8: begin w = (128'(x) * 128'd2) % two64; m_out = w[63:0]; end
            4'd9: m_out = x / 64'd2;
            default: ;
        endcase
    endtask

    task automatic check_out(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: out observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_rem(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: remainder observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive on the falling edge, let one rising edge load, sample 1 time unit later.
    task automatic step(input string tag, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        if (reset) model_apply(o, x, y);
        else begin
            m_out = '0;
            m_rem = '0;
        end
        check_out(tag, out, m_out);
        check_rem(tag, division_remainder, m_rem);
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return ONES;
            2: return 64'(1) << $urandom_range(0, 63);
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        op    = OP_ADD;
        a     = 64'd1;
        b     = 64'd1;
        m_out = '0;
        m_rem = '0;

        // Reset held low for 50 edges with an ADD on the inputs.
        repeat (50) @(posedge clk);
        #1;
        check_out("reset_out", out, 64'd0);
        check_rem("reset_rem", division_remainder, 65'd0);

        @(negedge clk);
        reset = 1'b1;
        step("first_add", OP_ADD, 64'd1, 64'd1);
        check_out("first_add_const", out, 64'd2);

        step("div_3_3", OP_DIV, 64'd3, 64'd3);
        check_out("div_3_3_q", out, 64'd1);
        check_rem("div_3_3_r", division_remainder, 65'd0);
        step("div_100_7", OP_DIV, 64'd100, 64'd7);
        check_out("div_100_7_q", out, 64'd14);
        check_rem("div_100_7_r", division_remainder, 65'd2);

        step("div_by_0", OP_DIV, 64'd5, 64'd0);
        check_out("div_by_0_q", out, ONES);
        check_rem("div_by_0_r", division_remainder, 65'd5);
        step("add_after_div0", OP_ADD, 64'd1, 64'd1);
        check_out("add_after_div0_out", out, 64'd2);
        check_rem("add_after_div0_rem", division_remainder, 65'd5);

        step("sub_1_1", OP_SUB, 64'd1, 64'd1);
        check_out("sub_1_1_const", out, 64'd0);
        step("sub_0_1", OP_SUB, 64'd0, 64'd1);
        check_out("sub_0_1_const", out, ONES);
        step("add_wrap", OP_ADD, ONES, 64'd1);
        check_out("add_wrap_const", out, 64'd0);

        step("mul_fffd", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD);
        check_out("mul_fffd_const", out, 64'd9);
        step("mul_2_32", OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000);
        check_out("mul_2_32_const", out, 64'd0);

        step("shl", OP_SHL, 64'h8000_0000_0000_0001, 64'd0);
        check_out("shl_const", out, 64'd2);
        step("shr", OP_SHR, 64'h8000_0000_0000_0001, 64'd0);
        check_out("shr_const", out, 64'h4000_0000_0000_0000);
        step("not", OP_NOT, 64'h8000_0000_0000_0001, 64'd0);
        check_out("not_const", out, 64'h7FFF_FFFF_FFFF_FFFE);
        step("op_1111_hold", 4'b1111, 64'h8000_0000_0000_0001, 64'd0);
        check_out("op_1111_hold_const", out, 64'h7FFF_FFFF_FFFF_FFFE);

        // Bitwise ops with a fixed pattern pair.
        step("and", OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        step("or",  OP_OR,  64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
        step("xor", OP_XOR, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);

        // Reset overrides a DIV sampled in the same cycle.
        @(negedge clk);
        reset = 1'b0;
        step("reset_over_div", OP_DIV, 64'd99, 64'd10);
        @(negedge clk);
        reset = 1'b1;
        step("after_mid_reset", OP_DIV, 64'd99, 64'd10);

        for (int i = 0; i < 400; i++) begin
            step("random", 4'($urandom_range(0, 15)), rand64(), rand64());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
